// File: rtl/mac_acc16_ctrl.sv
// Signed Q6.9 N_TAPS-tap MAC, round-half-up/saturate to Q9. Result valid 2 cycles after last transfer.
// in_ready_o low in DRAIN/OUT; result held until out_ready_i. Optional saturated-frame counter: MAC_ACC16_CTRL_SAT_CNT_EN.
module mac_acc16_ctrl #(
  parameter int N_TAPS = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [15:0] a_i,
  input  logic [15:0] x_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [35:0] y_ori_o,
  output logic [15:0] y_sat_o,
  output logic        sat_o,
  output logic        busy_o
`ifdef MAC_ACC16_CTRL_SAT_CNT_EN
  ,
  output logic [15:0] sat_cnt_o
`endif
);

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, OUT} state_t;

  localparam logic [4:0] LAST_TAP = 5'(N_TAPS - 1);

  state_t             state_q, state_d;
  logic [4:0]         tap_cnt_q, tap_cnt_d;
  logic               drain_ph_q, drain_ph_d;
  logic               load_out;
  logic               xfer;

  logic signed [15:0] a_s, x_s;
  logic signed [31:0] mul;
  logic signed [31:0] prod_q;
  logic               prod_vld_q;
  logic signed [35:0] acc_q;

  logic signed [27:0] y_rnd;
  logic        [15:0] y_sat_d;
  logic               sat_d;

  assign in_ready_o  = (state_q == IDLE) || (state_q == ACC);
  assign out_valid_o = (state_q == OUT);
  assign busy_o      = (state_q != IDLE);
  assign xfer        = in_valid_i & in_ready_o;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      tap_cnt_q  <= '0;
      drain_ph_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tap_cnt_q  <= tap_cnt_d;
      drain_ph_q <= drain_ph_d;
    end
  end

  // DRAIN spends one cycle folding in the last product, one cycle rounding into the output registers
  always_comb begin
    state_d    = state_q;
    tap_cnt_d  = tap_cnt_q;
    drain_ph_d = drain_ph_q;
    load_out   = 1'b0;
    case (state_q)
      IDLE: begin
        tap_cnt_d  = '0;
        drain_ph_d = 1'b0;
        if (xfer) begin
          tap_cnt_d = 5'd1;
          state_d   = (LAST_TAP == 5'd0) ? DRAIN : ACC;
        end
      end
      ACC: begin
        if (xfer) begin
          tap_cnt_d = tap_cnt_q + 5'd1;
          if (tap_cnt_q == LAST_TAP) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        drain_ph_d = 1'b1;
        if (drain_ph_q) begin
          load_out   = 1'b1;
          drain_ph_d = 1'b0;
          state_d    = OUT;
        end
      end
      OUT: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear_i) begin
      state_d    = IDLE;
      tap_cnt_d  = '0;
      drain_ph_d = 1'b0;
      load_out   = 1'b0;
    end
  end

  assign a_s = a_i;
  assign x_s = x_i;
  assign mul = 32'(a_s) * 32'(x_s);

  // Product stage P
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
    end else if (clear_i) begin
      prod_vld_q <= 1'b0;
    end else begin
      prod_vld_q <= xfer;
      if (xfer) begin
        prod_q <= mul;
      end
    end
  end

  // Accumulator; the first product of a frame lands one cycle after it leaves IDLE
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else if (clear_i || (state_q == IDLE)) begin
      acc_q <= '0;
    end else if (prod_vld_q) begin
      acc_q <= acc_q + 36'(prod_q);
    end
  end

  assign y_rnd = {acc_q[35], acc_q[35:9]} + {27'd0, acc_q[8]};

  always_comb begin
    y_sat_d = y_rnd[15:0];
    sat_d   = 1'b0;
    if (y_rnd > 28'sd32767) begin
      y_sat_d = 16'h7FFF;
      sat_d   = 1'b1;
    end else if (y_rnd < -28'sd32768) begin
      y_sat_d = 16'h8000;
      sat_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      y_ori_o <= '0;
      y_sat_o <= '0;
      sat_o   <= 1'b0;
    end else if (load_out) begin
      y_ori_o <= acc_q;
      y_sat_o <= y_sat_d;
      sat_o   <= sat_d;
    end
  end

`ifdef MAC_ACC16_CTRL_SAT_CNT_EN
  // A frame counts only when actually handed off; an abort in the same cycle wins
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sat_cnt_o <= '0;
    end else if (out_valid_o && out_ready_i && !clear_i && sat_o && (sat_cnt_o != 16'hFFFF)) begin
      sat_cnt_o <= sat_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mac_acc16_ctrl.sv
// Directed bench: a 16-tap instance (index 0) and a 1-tap instance (index 1) sharing clock and reset.
module tb_mac_acc16_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [1:0]       clr, in_vld, out_rdy;
  logic [1:0][15:0] a, x;
  wire  [1:0]       in_rdy, out_vld, sat, busy;
  wire  [1:0][35:0] y_ori;
  wire  [1:0][15:0] y_sat;
`ifdef MAC_ACC16_CTRL_SAT_CNT_EN
  wire  [1:0][15:0] sat_cnt;
`endif

  int checks = 0;
  int errors = 0;

  mac_acc16_ctrl #(.N_TAPS(16)) dut16 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr[0]),
    .in_valid_i(in_vld[0]), .in_ready_o(in_rdy[0]),
    .a_i(a[0]), .x_i(x[0]),
    .out_valid_o(out_vld[0]), .out_ready_i(out_rdy[0]),
    .y_ori_o(y_ori[0]), .y_sat_o(y_sat[0]), .sat_o(sat[0]), .busy_o(busy[0])
`ifdef MAC_ACC16_CTRL_SAT_CNT_EN
    , .sat_cnt_o(sat_cnt[0])
`endif
  );

  mac_acc16_ctrl #(.N_TAPS(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr[1]),
    .in_valid_i(in_vld[1]), .in_ready_o(in_rdy[1]),
    .a_i(a[1]), .x_i(x[1]),
    .out_valid_o(out_vld[1]), .out_ready_i(out_rdy[1]),
    .y_ori_o(y_ori[1]), .y_sat_o(y_sat[1]), .sat_o(sat[1]), .busy_o(busy[1])
`ifdef MAC_ACC16_CTRL_SAT_CNT_EN
    , .sat_cnt_o(sat_cnt[1])
`endif
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] x;
    logic [35:0] y_ori;
    logic [15:0] y_sat;
    logic        sat;
  } vec_t;

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [15:0] av, input logic [15:0] xv);
    in_vld[d] = 1'b1;
    a[d]      = av;
    x[d]      = xv;
    tick();
    in_vld[d] = 1'b0;
  endtask

  task automatic frame16(input logic [15:0] av, input logic [15:0] xv, input bit gaps);
    for (int i = 0; i < 16; i++) begin
      send(0, av, xv);
      if (gaps && (i % 5 == 2) && i != 15) tick();
    end
  endtask

  task automatic wait_out(input int d, output int lat);
    lat = 0;
    while (!out_vld[d] && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic take(input int d);
    out_rdy[d] = 1'b1;
    tick();
    out_rdy[d] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[11];
    int   lat;
    logic [35:0] held_ori;
    logic [15:0] held_sat;

    vecs[0]  = '{16'd16,   16'd16,   36'h000000100, 16'h0001, 1'b0};
    vecs[1]  = '{16'd15,   16'd17,   36'h0000000FF, 16'h0000, 1'b0};
    vecs[2]  = '{16'hFFF0, 16'd16,   36'hFFFFFFF00, 16'h0000, 1'b0};
    vecs[3]  = '{16'hFFEF, 16'd16,   36'hFFFFFFEF0, 16'hFFFF, 1'b0};
    vecs[4]  = '{16'd3,    16'd256,  36'h000000300, 16'h0002, 1'b0};
    vecs[5]  = '{16'd512,  16'd512,  36'h000040000, 16'h0200, 1'b0};
    vecs[6]  = '{16'h012C, 16'hFED4, 36'hFFFFEA070, 16'hFF50, 1'b0};
    vecs[7]  = '{16'h8000, 16'h8000, 36'h040000000, 16'h7FFF, 1'b1};
    vecs[8]  = '{16'h7FFF, 16'h8000, 36'hFC0008000, 16'h8000, 1'b1};
    vecs[9]  = '{16'h7FFF, 16'h0200, 36'h000FFFE00, 16'h7FFF, 1'b0};
    vecs[10] = '{16'h0FF0, 16'h1010, 36'h000FFFF00, 16'h7FFF, 1'b1};

    rst_n = 1'b0; clr = '0; in_vld = '0; out_rdy = '0; a = '0; x = '0;
    #12;
    chk("rst_out_valid", 36'(out_vld), 36'd0);
    chk("rst_busy",      36'(busy),    36'd0);
    chk("rst_y_ori",     y_ori[0],     36'd0);
    chk("rst_y_sat",     36'(y_sat[0]), 36'd0);
    chk("rst_sat",       36'(sat),     36'd0);
    rst_n = 1'b1;
    tick();
    chk("in_ready_after_rst", 36'(in_rdy), 36'h3);

    // Unity-ish frame: 16 * 2^18
    frame16(16'd512, 16'd512, 1'b0);
    wait_out(0, lat);
    chk("a_latency", 36'(lat), 36'd2);
    chk("a_y_ori",   y_ori[0], 36'h000400000);
    chk("a_y_sat",   36'(y_sat[0]), 36'd8192);
    chk("a_sat",     36'(sat[0]), 36'd0);
    take(0);
    chk("a_idle", 36'(busy[0]), 36'd0);

    // Positive saturation, with idle gaps inside the frame
    frame16(16'h7FFF, 16'h7FFF, 1'b1);
    wait_out(0, lat);
    chk("b_latency", 36'(lat), 36'd2);
    chk("b_y_ori",   y_ori[0], 36'h3FFF00010);
    chk("b_y_sat",   36'(y_sat[0]), 36'h7FFF);
    chk("b_sat",     36'(sat[0]), 36'd1);
    take(0);

    // Negative saturation
    frame16(16'h8000, 16'h7FFF, 1'b0);
    wait_out(0, lat);
    chk("c_y_ori", y_ori[0], 36'hC00080000);
    chk("c_y_sat", 36'(y_sat[0]), 36'h8000);
    chk("c_sat",   36'(sat[0]), 36'd1);
    take(0);

    // Single-tap rounding/saturation table
    for (int i = 0; i < 11; i++) begin
      send(1, vecs[i].a, vecs[i].x);
      wait_out(1, lat);
      chk($sformatf("v%0d_latency", i), 36'(lat), 36'd2);
      chk($sformatf("v%0d_y_ori", i), y_ori[1], vecs[i].y_ori);
      chk($sformatf("v%0d_y_sat", i), 36'(y_sat[1]), 36'(vecs[i].y_sat));
      chk($sformatf("v%0d_sat", i), 36'(sat[1]), 36'(vecs[i].sat));
      take(1);
    end

    // Output backpressure: 16 * (100 * -200) = -320000 -> -625
    frame16(16'd100, 16'hFF38, 1'b0);
    wait_out(0, lat);
    held_ori = y_ori[0];
    held_sat = y_sat[0];
    chk("e_y_ori", held_ori, 36'hFFFFB1E00);
    chk("e_y_sat", 36'(held_sat), 36'hFD8F);
    for (int i = 0; i < 5; i++) begin
      in_vld[0] = 1'b1; a[0] = 16'd1; x[0] = 16'd1;
      tick();
      chk($sformatf("e_hold%0d_valid", i), 36'(out_vld[0]), 36'd1);
      chk($sformatf("e_hold%0d_in_ready", i), 36'(in_rdy[0]), 36'd0);
      chk($sformatf("e_hold%0d_y_ori", i), y_ori[0], 36'hFFFFB1E00);
      chk($sformatf("e_hold%0d_y_sat", i), 36'(y_sat[0]), 36'hFD8F);
    end
    in_vld[0] = 1'b0;
    take(0);
    chk("e_release_valid", 36'(out_vld[0]), 36'd0);
    chk("e_release_busy",  36'(busy[0]), 36'd0);

    // Abort after 7 transfers; the clear cycle also presents a transfer that must be dropped
    for (int i = 0; i < 7; i++) send(0, 16'd1000, 16'd1000);
    clr[0] = 1'b1; in_vld[0] = 1'b1; a[0] = 16'd1000; x[0] = 16'd1000;
    tick();
    clr[0] = 1'b0; in_vld[0] = 1'b0;
    chk("f_clear_busy", 36'(busy[0]), 36'd0);
    frame16(16'd512, 16'd512, 1'b0);
    wait_out(0, lat);
    chk("f_latency", 36'(lat), 36'd2);
    chk("f_y_ori",   y_ori[0], 36'h000400000);
    chk("f_y_sat",   36'(y_sat[0]), 36'd8192);
    take(0);

    // Reset pulsed during DRAIN
    frame16(16'd512, 16'd512, 1'b0);
    chk("g_in_drain_busy", 36'(busy[0]), 36'd1);
    rst_n = 1'b0;
    #2;
    chk("g_rst_busy",  36'(busy[0]), 36'd0);
    chk("g_rst_y_ori", y_ori[0], 36'd0);
    rst_n = 1'b1;
    lat = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_vld[0]) lat++;
    end
    chk("g_no_output", 36'(lat), 36'd0);
    chk("g_in_ready", 36'(in_rdy[0]), 36'd1);

`ifdef MAC_ACC16_CTRL_SAT_CNT_EN
    chk("h_cnt_after_rst", 36'(sat_cnt[0]), 36'd0);
    for (int f = 0; f < 2; f++) begin
      frame16(16'h7FFF, 16'h7FFF, 1'b0);
      wait_out(0, lat);
      take(0);
    end
    chk("h_cnt_two", 36'(sat_cnt[0]), 36'd2);
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    chk("h_cnt_kept_by_clear", 36'(sat_cnt[0]), 36'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
